// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, imem req/ack fetch, one-entry decode buffer.
// Optional consumed-instruction counter enabled by defining FETCH_STAT_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    output logic [31:0] pc4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_err
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        consume;
    logic        npc_aligned;

    // valid_q is only ever set in HOLD, so this is the HOLD-state consume
    assign consume     = valid_q & inst_ready;
    assign npc_aligned = (npc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imem_ack) state_d = HOLD;
            HOLD:  if (consume) state_d = npc_aligned ? FETCH : FAULT;
            FAULT: state_d = FAULT;
        endcase
    end

    always_comb begin
        imem_req   = (state_q == FETCH);
        imem_addr  = pc_q;
        pc4        = pc_q + 32'd4;
        inst_valid = valid_q;
        inst       = inst_q;
        inst_pc    = inst_pc_q;
        fetch_err  = err_q;
    end

    always_comb begin
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        err_d     = err_q;
        if (state_q == FETCH && imem_ack) begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
        end
        if (consume) begin
            valid_d = 1'b0;
            pc_d    = npc;
            err_d   = ~npc_aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

`ifdef FETCH_STAT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (consume) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with RESET_PC = 0000_3000.
// Counter checks are included when FETCH_STAT_EN is defined.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic [31:0] pc4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_err;
`ifdef FETCH_STAT_EN
    logic [31:0] fetch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .pc4        (pc4),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err)
`ifdef FETCH_STAT_EN
        ,
        .fetch_cnt  (fetch_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_hold(input string tag, input logic [31:0] ex_inst,
                            input logic [31:0] ex_pc);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_inst"}, inst, ex_inst);
        chk({tag, "_inst_pc"}, inst_pc, ex_pc);
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] ex_addr);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_addr"}, imem_addr, ex_addr);
    endtask

    initial begin
        rst        = 1'b1;
        npc        = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        inst_ready = 1'b0;

        // reset
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_pc4", pc4, 32'h0000_3004);
        chk("rst_addr", imem_addr, 32'h0000_3000);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
`ifdef FETCH_STAT_EN
        chk("rst_cnt", fetch_cnt, 32'd0);
`endif

        // IDLE pass: ack here must be ignored
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk_fetch("first", 32'h0000_3000);

        // zero-wait sequential flow
        imem_rdata = 32'hA000_0000;
        inst_ready = 1'b1;
        npc        = 32'h0000_3004;
        tick();
        imem_rdata = 32'hDEAD_0001;
        chk_hold("seq0", 32'hA000_0000, 32'h0000_3000);
        tick();
        chk_fetch("seq1f", 32'h0000_3004);
`ifdef FETCH_STAT_EN
        chk("cnt1", fetch_cnt, 32'd1);
`endif
        imem_rdata = 32'hA000_0004;
        npc        = 32'h0000_3008;
        tick();
        imem_rdata = 32'hDEAD_0002;
        chk_hold("seq1", 32'hA000_0004, 32'h0000_3004);
        tick();
        chk_fetch("seq2f", 32'h0000_3008);
        chk("seq2_pc4", pc4, 32'h0000_300C);
        imem_rdata = 32'hA000_0008;
        inst_ready = 1'b0;
        tick();
        chk_hold("seq2", 32'hA000_0008, 32'h0000_3008);

        // memory wait of 3 cycles
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        npc        = 32'h0000_300C;
        tick();
        inst_ready = 1'b1;
        npc        = 32'h7777_7770;
        for (int i = 0; i < 3; i++) begin
            chk_fetch("wait", 32'h0000_300C);
            tick();
        end
        chk_fetch("wait_end", 32'h0000_300C);
        imem_ack   = 1'b1;
        imem_rdata = 32'hB000_000C;
        inst_ready = 1'b0;
        tick();
        chk_hold("waitack", 32'hB000_000C, 32'h0000_300C);

        // decode backpressure for 5 cycles, npc wandering
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_0003;
        for (int i = 0; i < 5; i++) begin
            npc = 32'h5555_5550 + 32'(i);
            tick();
            chk_hold("bp", 32'hB000_000C, 32'h0000_300C);
            chk("bp_addr", imem_addr, 32'h0000_300C);
        end
        npc        = 32'h0000_4000;
        inst_ready = 1'b1;
        tick();
        chk_fetch("bp_rel", 32'h0000_4000);
        chk("bp_pc4", pc4, 32'h0000_4004);

        // ready with nothing buffered has no effect
        npc = 32'h0000_9000;
        tick();
        chk_fetch("rdy_idle", 32'h0000_4000);
        imem_ack   = 1'b1;
        imem_rdata = 32'hC000_4000;
        inst_ready = 1'b0;
        tick();
        chk_hold("c0", 32'hC000_4000, 32'h0000_4000);

        // misaligned jump
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        npc        = 32'h0000_4002;
        tick();
        chk("mis_err", {31'd0, fetch_err}, 32'd1);
        chk("mis_addr", imem_addr, 32'h0000_4002);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_valid", {31'd0, inst_valid}, 32'd0);
`ifdef FETCH_STAT_EN
        chk("mis_cnt", fetch_cnt, 32'd5);
`endif
        imem_ack = 1'b1;
        npc      = 32'h0000_8000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flt_err", {31'd0, fetch_err}, 32'd1);
            chk("flt_req", {31'd0, imem_req}, 32'd0);
            chk("flt_addr", imem_addr, 32'h0000_4002);
            chk("flt_valid", {31'd0, inst_valid}, 32'd0);
        end

        // reset clears fault and restarts at RESET_PC
        rst      = 1'b1;
        imem_ack = 1'b0;
        tick();
        chk("clr_err", {31'd0, fetch_err}, 32'd0);
        chk("clr_addr", imem_addr, 32'h0000_3000);
        chk("clr_req", {31'd0, imem_req}, 32'd0);
`ifdef FETCH_STAT_EN
        chk("clr_cnt", fetch_cnt, 32'd0);
`endif
        rst = 1'b0;
        tick();
        chk_fetch("restart", 32'h0000_3000);

        // reset discards a buffered instruction
        imem_ack   = 1'b1;
        imem_rdata = 32'hD000_3000;
        inst_ready = 1'b0;
        tick();
        chk_hold("d0", 32'hD000_3000, 32'h0000_3000);
        rst = 1'b1;
        tick();
        chk("disc_valid", {31'd0, inst_valid}, 32'd0);
        chk("disc_inst", inst, 32'd0);
        chk("disc_inst_pc", inst_pc, 32'd0);

        // PC+4 wraps modulo 2^32
        rst = 1'b0;
        tick();
        tick();
        chk_hold("e0", 32'hD000_3000, 32'h0000_3000);
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        npc        = 32'hFFFF_FFFC;
        tick();
        chk_fetch("wrap", 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0000_0000);

`ifdef FETCH_STAT_EN
        chk("w_cnt", fetch_cnt, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hE000_0000;
        inst_ready = 1'b0;
        tick();
        force dut.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_q;
        chk("pre_cnt", fetch_cnt, 32'hFFFF_FFFF);
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        npc        = 32'h0000_0100;
        tick();
        chk("cnt_wrap", fetch_cnt, 32'd0);
        imem_ack = 1'b1;
        tick();
        tick();
        chk("cnt_after", fetch_cnt, 32'd1);
        chk_fetch("cnt_f", 32'h0000_0100);
        imem_ack = 1'b0;
        rst      = 1'b1;
        tick();
        chk("cnt_rst", fetch_cnt, 32'd0);
        chk("cnt_rst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
